digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered inter-digit carry. It has a valid/ready handshake on both the input and output sides. It is the area-lean successor to the single-bit half/full adder cells and is intended for wide arithmetic in datapaths that are not timing-critical. Operands are captured on acceptance, so the upstream source may change them immediately afterwards.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH. WIDTH % DIGIT ≠ 0 is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in ADD or DONE.
- ovf  output  1  signed overflow flag; this port exists only under DIGIT_SERIAL_ADDER_OVF_EN.

## Operation
- N = WIDTH/DIGIT digits. The digit counter is max(1, $clog2(N)) bits wide.
- States and transitions:
  - IDLE → ADD on in_valid && in_ready. On that edge, capture a, b and cin, clear the counter, and clear the sum register.
  - ADD, per cycle at counter value k: compute {c, s} = a[k*DIGIT +: DIGIT] + b[k*DIGIT +: DIGIT] + carry_reg, as a DIGIT+1-bit result. Write s to sum[k*DIGIT +: DIGIT], write c to carry_reg, and increment the counter.
  - ADD → DONE on the edge where k = N-1. On that edge, cout takes the final c.
  - DONE → IDLE on out_valid && out_ready.
- carry_reg is loaded with cin on acceptance.
- sum, cout and ovf are registered. They are held stable for the whole time out_valid is high, and they keep their last value in IDLE.
- There is no input/output overlap. in_ready is low in DONE, so a new operation cannot be accepted in the same cycle the result transfers.
- Reset, including reset in the middle of an operation, is asynchronous. It forces state IDLE and discards any operation in flight. Output values while reset is asserted:
  - in_ready = 1
  - out_valid = 0, busy = 0
  - sum = 0, cout = 0, ovf = 0
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Acceptance edge at cycle t. ADD occupies cycles t+1 … t+N.
- out_valid rises after edge t+N, so latency is N cycles from acceptance to out_valid.
- With out_ready held high, in_ready returns one cycle after the result transfer.
- Maximum throughput is one operation per N+2 cycles.
- in_ready, out_valid and busy are decoded directly from state registers; there is no combinational path from any input.
- Critical path is one DIGIT+1-bit add plus the carry register.

## Configuration
- DIGIT_SERIAL_ADDER_OVF_EN defined:
  - The ovf port and its register exist.
  - On the final ADD edge, ovf = carry into the MSB XOR carry out of the MSB.
  - ovf is cleared on acceptance and on reset.
- Undefined:
  - There is no ovf port and no associated logic.
  - All other behaviour is identical.

## Test plan
Defaults WIDTH=16, DIGIT=4 (N=4) unless stated otherwise.
- Basic add: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid asserts exactly 4 cycles after acceptance, and in_ready is low throughout.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Also a=0xFFFF, b=0x0001, cin=0 → same result.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid stays 1, sum/cout are stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready gives IDLE one cycle later.
- Reset mid-operation: assert rst_n=0 at ADD k=2 → in_ready=1, out_valid=0, sum=0 immediately. A following a=0x0001, b=0x0001 operation returns sum=0x0002.
- Overflow (OVF_EN defined):
  - 0x7FFF + 0x0001 → sum=0x8000, ovf=1, cout=0.
  - 0x8000 + 0x8000 → sum=0x0000, ovf=1, cout=1.
  - 0xFFFF + 0x0001 → ovf=0.
- Degenerate widths:
  - DIGIT=WIDTH=8: 0xF0 + 0x0F + cin=1 → sum=0x00, cout=1, latency 1.
  - DIGIT=1, WIDTH=8: same operands → same result, latency 8.

Source files
------------

// File: rtl/digit_serial_adder_if.sv
// Handshake/data bundle for digit_serial_adder.
// The ovf signal exists only when DIGIT_SERIAL_ADDER_OVF_EN is defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, DIGIT bits per clock with a registered carry.
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the signed-overflow flag (ovf).
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             last;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Operands shift right each ADD cycle, so the active digit is always the low DIGIT bits.
  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    last = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nx = ADD;
      ADD:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
            sum_q   <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        ADD: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dsum[DIGIT];
          cnt     <= cnt + 1'b1;
          for (int unsigned k = 0; k < N; k++) begin
            if (cnt == CW'(k)) sum_q[k*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
          end
          if (last) begin
            cout_q <= dsum[DIGIT];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            // Carry into the MSB is recovered as a ^ b ^ s at that bit position.
            ovf_q  <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: 16/4 main instance plus 8/8 and 8/1 degenerate instances.
module tb_digit_serial_adder;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(W)) bus  ();
  digit_serial_adder_if #(.WIDTH(8)) bus8 ();
  digit_serial_adder_if #(.WIDTH(8)) bus1 ();

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 adding, 2 result held; result from plain arithmetic.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W:0]   m_pend  = '0;
  logic         m_povf  = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          m_pend  = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
          m_povf  = (bus.a[W-1] == bus.b[W-1]) && (m_pend[W-1] != bus.a[W-1]);
          m_ovf   = 1'b0;
          m_left  = N;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_sum   = m_pend[W-1:0];
            m_cout  = m_pend[W];
            m_ovf   = m_povf;
          end
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      chk("busy",      32'(bus.busy),      32'(m_phase != 0));
      if (m_phase != 1) begin
        chk("sum",  32'(bus.sum),  32'(m_sum));
        chk("cout", 32'(bus.cout), 32'(m_cout));
      end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                       input int hold, output logic [W-1:0] rs, output logic rc,
                       output logic ro, output int lat);
    int g;
    @(negedge clk);
    bus.a = ta; bus.b = tb2; bus.cin = tc; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    g = 0;
    while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept_wait", 32'(g < 50), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(N));
    rs = bus.sum;
    rc = bus.cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ro = bus.ovf;
`else
    ro = 1'b0;
`endif
    repeat (hold) begin
      bus.in_valid = 1'($urandom);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat;

    bus.in_valid  = 1'b0; bus.out_ready  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_cout",      32'(bus.cout),      32'd0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 0, rs, rc, ro, lat);
    chk("basic_sum", 32'(rs), 32'h5555);
    chk("basic_cout", 32'(rc), 32'd0);

    do_op(16'hFFFF, 16'h0000, 1'b1, 0, rs, rc, ro, lat);
    chk("ripple1_sum", 32'(rs), 32'h0000);
    chk("ripple1_cout", 32'(rc), 32'd1);

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
    chk("ripple2_sum", 32'(rs), 32'h0000);
    chk("ripple2_cout", 32'(rc), 32'd1);

    do_op(16'hA5A5, 16'h1111, 1'b0, 6, rs, rc, ro, lat);
    chk("bp_sum", 32'(rs), 32'hB6B6);
    chk("bp_idle_after_release", 32'(bus.in_ready), 32'd1);

    do_op(16'h7FFF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
    chk("ovf1_sum", 32'(rs), 32'h8000);
    chk("ovf1_cout", 32'(rc), 32'd0);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("ovf1_ovf", 32'(ro), 32'd1);
`endif
    do_op(16'h8000, 16'h8000, 1'b0, 0, rs, rc, ro, lat);
    chk("ovf2_sum", 32'(rs), 32'h0000);
    chk("ovf2_cout", 32'(rc), 32'd1);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("ovf2_ovf", 32'(ro), 32'd1);
`endif
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("ovf3_ovf", 32'(ro), 32'd0);
`endif

    // Reset while the third digit (k=2) is being added.
    @(negedge clk);
    bus.a = 16'h0F0F; bus.b = 16'h7070; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'd0);
    chk("midrst_cout",      32'(bus.cout),      32'd0);
    #1 rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
    chk("post_rst_sum", 32'(rs), 32'h0002);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rcin;
      logic [W:0]   ex;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom);
      ex   = {1'b0, ra} + {1'b0, rb} + (W+1)'(rcin);
      do_op(ra, rb, rcin, $urandom_range(0, 3), rs, rc, ro, lat);
      chk("rand_sum", 32'(rs), 32'(ex[W-1:0]));
    end

    for (int it = 0; it < 4; it++) begin
      logic [7:0] sa, sb, s8, s1;
      logic       sc, c8, c1;
      logic [8:0] ex;
      int         l8, l1;
      if (it == 0) begin
        sa = 8'hF0; sb = 8'h0F; sc = 1'b1;
      end else begin
        sa = 8'($urandom); sb = 8'($urandom); sc = 1'($urandom);
      end
      ex = {1'b0, sa} + {1'b0, sb} + 9'(sc);
      @(negedge clk);
      bus8.a = sa; bus8.b = sb; bus8.cin = sc; bus8.in_valid = 1'b1;
      bus1.a = sa; bus1.b = sb; bus1.cin = sc; bus1.in_valid = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus1.in_valid = 1'b0; bus1.a = 8'($urandom); bus1.b = 8'($urandom);
      l8 = -1; l1 = -1; s8 = '0; s1 = '0; c8 = 1'b0; c1 = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (bus8.out_valid && l8 < 0) begin l8 = c; s8 = bus8.sum; c8 = bus8.cout; end
        if (bus1.out_valid && l1 < 0) begin l1 = c; s1 = bus1.sum; c1 = bus1.cout; end
        if (l8 >= 0 && l1 >= 0) break;
        @(negedge clk);
      end
      chk("d8_latency", 32'(l8), 32'd1);
      chk("d1_latency", 32'(l1), 32'd8);
      chk("d8_sum",  32'(s8), 32'(ex[7:0]));
      chk("d8_cout", 32'(c8), 32'(ex[8]));
      chk("d1_sum",  32'(s1), 32'(ex[7:0]));
      chk("d1_cout", 32'(c1), 32'(ex[8]));
      if (it == 0) begin
        chk("d8_lit_sum",  32'(s8), 32'h00);
        chk("d8_lit_cout", 32'(c8), 32'd1);
      end
      bus8.out_ready = 1'b1; bus1.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0; bus1.out_ready = 1'b0;
      chk("d8_idle", 32'(bus8.in_ready), 32'd1);
      chk("d1_idle", 32'(bus1.in_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
